kgp_fetch: RTL and testbench

KGP_FETCH -- requirements
Module: kgp_fetch

---
 rtl/kgp_pkg.sv | 30 +++
 rtl/kgp_fetch_if.sv | 39 +++
 rtl/kgp_pc_reg.sv | 38 +++
 rtl/kgp_fetch.sv | 140 ++++++++++++++
 tb/tb_kgp_fetch.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kgp_pkg.sv
// Shared types and constants for the kgp instruction fetch unit.
package kgp_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALEN    = 32;
    localparam int unsigned FIELD_W = 6;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned FN_LSB  = 0;

    localparam logic [XLEN-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [ALEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [ALEN-1:0] INSTR_BYTES   = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } kgp_state_e;

    // Targets from the branch unit are always treated as word aligned.
    function automatic logic [ALEN-1:0] word_align(input logic [ALEN-1:0] a);
        return a & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/kgp_fetch_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input, decoder handshake.
interface kgp_fetch_if;
    import kgp_pkg::*;

    logic                 imem_req;
    logic [ALEN-1:0]      imem_addr;
    logic                 imem_rvalid;
    logic [XLEN-1:0]      imem_rdata;

    logic                 redir_valid;
    logic [ALEN-1:0]      redir_pc;

    logic                 dec_valid;
    logic                 dec_ready;
    logic [XLEN-1:0]      instr;
    logic [ALEN-1:0]      pc;
    logic [ALEN-1:0]      pc_plus4;
    logic [FIELD_W-1:0]   opcode;
    logic [FIELD_W-1:0]   functcode;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redir_valid, redir_pc,
        output dec_valid,
        input  dec_ready,
        output instr, pc, pc_plus4, opcode, functcode
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redir_valid, redir_pc,
        input  dec_valid,
        output dec_ready,
        input  instr, pc, pc_plus4, opcode, functcode
    );

endinterface

// File: rtl/kgp_pc_reg.sv
// Fetch address register with sequential +4 advance and branch redirect mux.
module kgp_pc_reg
    import kgp_pkg::*;
#(
    parameter logic [ALEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            redir_take,
    input  logic [ALEN-1:0] redir_pc,
    output logic [ALEN-1:0] fetch_pc
);

    logic [ALEN-1:0] fetch_pc_q;
    logic [ALEN-1:0] fetch_pc_d;

    // A redirect wins over the sequential advance taken in the same cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redir_take) begin
            fetch_pc_d = word_align(redir_pc);
        end else if (advance) begin
            fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/kgp_fetch.sv
// Instruction fetch FSM: one outstanding read, holds a word for the decoder.
// Optional KGP_FETCH_PERF_EN adds the br_count redirect counter output.
//   state | meaning
//   IDLE  | one cycle after reset before the first request
//   REQ   | imem_req asserted with imem_addr = fetch_pc
//   WAIT  | waiting for imem_rvalid (response dropped if drop is set)
//   HOLD  | instruction presented to decoder, dec_valid = 1
//   HALT  | halt word delivered; only reset leaves
module kgp_fetch
    import kgp_pkg::*;
#(
    parameter logic [ALEN-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [XLEN-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic          clk,
    input  logic          rst_n,
    kgp_fetch_if.master   bus,
    output logic          halted
`ifdef KGP_FETCH_PERF_EN
    ,
    output logic [15:0]   br_count
`endif
);

    kgp_state_e      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [ALEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;

    logic            advance;
    logic            redir_take;
    logic [ALEN-1:0] fetch_pc;

    assign redir_take = bus.redir_valid && (state_q != ST_HALT);

    kgp_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .redir_take (redir_take),
        .redir_pc   (bus.redir_pc),
        .fetch_pc   (fetch_pc)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                if (bus.redir_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    // A response racing a redirect belongs to the old path.
                    if (drop_q || bus.redir_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d = bus.imem_rdata;
                        pc_d    = fetch_pc;
                        advance = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (bus.redir_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.redir_valid) begin
                    state_d = ST_REQ;
                end else if (bus.dec_ready) begin
                    state_d = (instr_q == HALT_WORD) ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.imem_req  = (state_q == ST_REQ);
    assign bus.imem_addr = fetch_pc;
    assign bus.dec_valid = (state_q == ST_HOLD);
    assign bus.instr     = instr_q;
    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_q + INSTR_BYTES;
    assign bus.opcode    = instr_q[OPC_MSB:OPC_LSB];
    assign bus.functcode = instr_q[FN_MSB:FN_LSB];
    assign halted        = (state_q == ST_HALT);

`ifdef KGP_FETCH_PERF_EN
    logic [15:0] br_count_q, br_count_d;

    always_comb begin
        br_count_d = br_count_q;
        if (redir_take && (br_count_q != 16'hFFFF)) begin
            br_count_d = br_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count_q <= 16'd0;
        end else begin
            br_count_q <= br_count_d;
        end
    end

    assign br_count = br_count_q;
`endif

endmodule

// File: tb/tb_kgp_fetch.sv
// Self-checking bench for kgp_fetch: latency-programmable memory, delivery scoreboard.
module tb_kgp_fetch;
    import kgp_pkg::*;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_HALT     = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    logic halted;
`ifdef KGP_FETCH_PERF_EN
    logic [15:0] br_count;
`endif

    kgp_fetch_if bus();

    kgp_fetch #(
        .RESET_PC  (T_RESET_PC),
        .HALT_WORD (T_HALT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halted (halted)
`ifdef KGP_FETCH_PERF_EN
        ,
        .br_count (br_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_deliv  = 0;
    int now      = 0;

    // reference model: address of the next instruction the decoder must see
    logic [31:0] exp_next = T_RESET_PC;
    bit          halted_m = 1'b0;
    int          br_m     = 0;

    int          lat       = 1;
    bit          rand_lat  = 1'b0;
    bit          spur_en   = 1'b0;
    bit          halt_en   = 1'b0;
    logic [31:0] halt_addr = 32'h0000_0100;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;
    rsp_t rq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == halt_addr) return T_HALT;
        return a ^ 32'h1234_5678;
    endfunction

    // Scores the cycle about to be clocked, then advances to the next negedge.
    task automatic cyc();
        logic [31:0] e_instr;
        logic [5:0]  e_opc;
        logic [5:0]  e_fn;
        rsp_t        r;
        if (!rst_n) begin
            exp_next = T_RESET_PC;
            halted_m = 1'b0;
            br_m     = 0;
        end else begin
            n_checks++;
            if (halted !== halted_m) begin
                n_fail++;
                $display("FAIL halted_flag: got %b required %b at cycle %0d", halted, halted_m, now);
            end
            if (halted_m) begin
                n_checks++;
                if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_quiet: imem_req=%b dec_valid=%b required 0 0", bus.imem_req, bus.dec_valid);
                end
            end else if (bus.redir_valid) begin
                exp_next = bus.redir_pc & 32'hFFFF_FFFC;
                if (br_m < 65535) br_m++;
            end else if (bus.dec_valid === 1'b1 && bus.dec_ready) begin
                e_instr = mem_word(exp_next);
                e_opc   = e_instr[31:26];
                e_fn    = e_instr[5:0];
                n_checks++;
                if (bus.pc !== exp_next || bus.instr !== e_instr || bus.pc_plus4 !== exp_next + 32'd4 ||
                    bus.opcode !== e_opc || bus.functcode !== e_fn) begin
                    n_fail++;
                    $display("FAIL deliver: got pc=%h instr=%h pc_plus4=%h opc=%h fn=%h required pc=%h instr=%h pc_plus4=%h opc=%h fn=%h",
                             bus.pc, bus.instr, bus.pc_plus4, bus.opcode, bus.functcode,
                             exp_next, e_instr, exp_next + 32'd4, e_opc, e_fn);
                end
                n_deliv++;
                if (e_instr == T_HALT) halted_m = 1'b1;
                exp_next = exp_next + 32'd4;
            end
        end
        @(negedge clk);
        now++;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (rq.size() > 0 && rq[0].due == now) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(rq[0].addr);
            void'(rq.pop_front());
        end else if (rq.size() == 0 && spur_en && $urandom_range(0, 7) == 0) begin
            bus.imem_rvalid = 1'b1;
        end
        if (bus.imem_req === 1'b1) begin
            r.due  = now + (rand_lat ? int'($urandom_range(1, 4)) : lat);
            r.addr = bus.imem_addr;
            rq.push_back(r);
        end
    endtask

    task automatic wait_dv(input int budget, input string name);
        int k = 0;
        while (bus.dec_valid !== 1'b1 && k < budget) begin
            cyc();
            k++;
        end
        n_checks++;
        if (bus.dec_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: dec_valid=%b after %0d cycles, required 1", name, bus.dec_valid, k);
        end
    endtask

    task automatic wait_req(input int budget, input string name);
        int k = 0;
        while (bus.imem_req !== 1'b1 && k < budget) begin
            cyc();
            k++;
        end
        n_checks++;
        if (bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: imem_req=%b after %0d cycles, required 1", name, bus.imem_req, k);
        end
    endtask

    // Waits for the next request while confirming nothing reaches the decoder.
    task automatic wait_req_no_dv(input int budget, input string name);
        int k     = 0;
        bit stale = 1'b0;
        while (bus.imem_req !== 1'b1 && k < budget) begin
            if (bus.dec_valid !== 1'b0) stale = 1'b1;
            cyc();
            k++;
        end
        n_checks++;
        if (stale || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_no_stale: dec_valid_seen=%b imem_req=%b required 0 1", name, stale, bus.imem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0 || halted !== 1'b0 ||
            bus.pc !== T_RESET_PC || bus.instr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b dv=%b halted=%b pc=%h instr=%h required 0 0 0 %h 0",
                     bus.imem_req, bus.dec_valid, halted, bus.pc, bus.instr, T_RESET_PC);
        end
`ifdef KGP_FETCH_PERF_EN
        n_checks++;
        if (br_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_br_count: got %0d required 0", br_count);
        end
`endif
    endtask

    task automatic test_sequence();
        int          first_dv = -1;
        int          na       = 0;
        logic [31:0] addrs[3];
        lat       = 1;
        dec_ready_set(1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (first_dv < 0 && bus.dec_valid === 1'b1) first_dv = i;
            if (bus.imem_req === 1'b1 && na < 3) begin
                addrs[na] = bus.imem_addr;
                na++;
            end
        end
        n_checks++;
        if (first_dv != 3) begin
            n_fail++;
            $display("FAIL first_dec_valid: got cycle %0d required 3", first_dv);
        end
        n_checks++;
        if (na != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL addr_sequence: got n=%0d %h %h %h required 3 0 4 8", na, addrs[0], addrs[1], addrs[2]);
        end
    endtask

    task automatic dec_ready_set(input logic v);
        bus.dec_ready = v;
    endtask

    task automatic test_hold_stall();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        lat = 3;
        dec_ready_set(1'b0);
        wait_dv(40, "stall");
        e_pc    = exp_next;
        e_instr = mem_word(e_pc);
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if (bus.dec_valid !== 1'b1 || bus.pc !== e_pc || bus.instr !== e_instr || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable: dv=%b pc=%h instr=%h req=%b required 1 %h %h 0",
                         bus.dec_valid, bus.pc, bus.instr, bus.imem_req, e_pc, e_instr);
            end
        end
        dec_ready_set(1'b1);
        cyc();
        dec_ready_set(1'b0);
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== e_pc + 32'd4) begin
            n_fail++;
            $display("FAIL after_stall_req: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, e_pc + 32'd4);
        end
    endtask

    task automatic test_redir_wait();
        lat = 3;
        dec_ready_set(1'b1);
        wait_req(40, "rw_req");
        cyc();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0040;
        cyc();
        bus.redir_valid = 1'b0;
        wait_req_no_dv(20, "redir_wait");
        n_checks++;
        if (bus.imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_wait_addr: got %h required 00000040", bus.imem_addr);
        end
        wait_dv(20, "rw_dv");
        n_checks++;
        if (bus.pc !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_wait_pc: got %h required 00000040", bus.pc);
        end
    endtask

    task automatic test_redir_hold();
        dec_ready_set(1'b0);
        wait_dv(40, "rh_dv");
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0203;
        dec_ready_set(1'b1);
        cyc();
        bus.redir_valid = 1'b0;
        n_checks++;
        if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_hold_cancel: dv=%b req=%b addr=%h required 0 1 00000200",
                     bus.dec_valid, bus.imem_req, bus.imem_addr);
        end
        wait_dv(20, "rh_dv2");
        n_checks++;
        if (bus.pc !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_hold_pc: got %h required 00000200", bus.pc);
        end
    endtask

    task automatic test_redir_req();
        dec_ready_set(1'b1);
        wait_req(40, "rr_req");
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'h0000_0300;
        cyc();
        bus.redir_valid = 1'b0;
        wait_req_no_dv(20, "redir_req");
        n_checks++;
        if (bus.imem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL redir_req_addr: got %h required 00000300", bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        dec_ready_set(1'b0);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 32'hFFFF_FFFC;
        cyc();
        bus.redir_valid = 1'b0;
        wait_dv(40, "wrap_dv");
        n_checks++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc_plus4: pc=%h pc_plus4=%h required fffffffc 00000000", bus.pc, bus.pc_plus4);
        end
        dec_ready_set(1'b1);
        cyc();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_next_addr: req=%b addr=%h required 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        int n0 = n_deliv;
        spur_en  = 1'b1;
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.redir_valid = ($urandom_range(0, 15) == 0);
            bus.redir_pc    = $urandom;
            dec_ready_set(1'($urandom_range(0, 1)));
            cyc();
        end
        bus.redir_valid = 1'b0;
        cyc();
        spur_en  = 1'b0;
        rand_lat = 1'b0;
        n_checks++;
        if (n_deliv - n0 < 50) begin
            n_fail++;
            $display("FAIL random_progress: got %0d deliveries required at least 50", n_deliv - n0);
        end
`ifdef KGP_FETCH_PERF_EN
        n_checks++;
        if (int'(br_count) != br_m) begin
            n_fail++;
            $display("FAIL random_br_count: got %0d required %0d", br_count, br_m);
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        lat = 2;
        dec_ready_set(1'b1);
        wait_req(40, "rmw_req");
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== T_RESET_PC) begin
            n_fail++;
            $display("FAIL reset_mid_wait_req: req=%b addr=%h required 1 %h", bus.imem_req, bus.imem_addr, T_RESET_PC);
        end
        wait_dv(20, "rmw_dv");
        n_checks++;
        if (bus.pc !== T_RESET_PC || bus.instr !== mem_word(T_RESET_PC)) begin
            n_fail++;
            $display("FAIL reset_mid_wait_data: pc=%h instr=%h required %h %h",
                     bus.pc, bus.instr, T_RESET_PC, mem_word(T_RESET_PC));
        end
    endtask

    task automatic test_halt();
        lat     = 1;
        halt_en = 1'b1;
        dec_ready_set(1'b1);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = halt_addr;
        cyc();
        bus.redir_valid = 1'b0;
        wait_dv(20, "halt_dv");
        n_checks++;
        if (bus.instr !== T_HALT || bus.pc !== halt_addr) begin
            n_fail++;
            $display("FAIL halt_word: instr=%h pc=%h required %h %h", bus.instr, bus.pc, T_HALT, halt_addr);
        end
        cyc();
        for (int i = 0; i < 20; i++) begin
            bus.redir_valid = 1'($urandom_range(0, 1));
            bus.redir_pc    = $urandom;
            cyc();
            n_checks++;
            if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold: halted=%b req=%b required 1 0", halted, bus.imem_req);
            end
        end
        bus.redir_valid = 1'b0;
`ifdef KGP_FETCH_PERF_EN
        n_checks++;
        if (int'(br_count) != br_m) begin
            n_fail++;
            $display("FAIL halt_br_count: got %0d required %0d", br_count, br_m);
        end
`endif
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== T_RESET_PC) begin
            n_fail++;
            $display("FAIL halt_restart: halted=%b req=%b addr=%h required 0 1 %h",
                     halted, bus.imem_req, bus.imem_addr, T_RESET_PC);
        end
        halt_en = 1'b0;
    endtask

`ifdef KGP_FETCH_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.redir_valid = 1'b1;
            bus.redir_pc    = $urandom;
            cyc();
        end
        bus.redir_valid = 1'b0;
        cyc();
        n_checks++;
        if (br_count !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_br_count: got %0d required 3", br_count);
        end
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
        bus.dec_ready   = 1'b0;

        test_reset();
        test_sequence();
        test_hold_stall();
        test_redir_wait();
        test_redir_hold();
        test_redir_req();
        test_wrap();
        test_random();
        test_reset_mid_wait();
        test_halt();
`ifdef KGP_FETCH_PERF_EN
        test_perf();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
